// File: rtl/hpc3_rnd_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// hpc3_rnd_dispatch_pkg : shared sizing helpers for the HPC3 randomness path
// Rev 1.0
// ============================================================================
package hpc3_rnd_dispatch_pkg;

  // Buffer operation selected each cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    BUF_HOLD = 2'b00,
    BUF_POP  = 2'b01,
    BUF_PUSH = 2'b10,
    BUF_BOTH = 2'b11
  } buf_op_e;

  // One HPC3 gadget needs d(d-1)/2 bits for r and the same again for r'.
  function automatic int hpc3_rnd_bits(input int shares);
    return shares * (shares - 1);
  endfunction

  function automatic int out_width(input int shares, input int ngadgets);
    return ngadgets * hpc3_rnd_bits(shares);
  endfunction

  function automatic int clog2_fn(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpc3_rnd_dispatch_rnd_bitbuf.sv
`default_nettype none
// ============================================================================
// hpc3_rnd_dispatch_rnd_bitbuf : LSB-first bit FIFO with fixed push/pop widths
// Rev 1.0
// ============================================================================
module hpc3_rnd_dispatch_rnd_bitbuf
  import hpc3_rnd_dispatch_pkg::*;
#(
  parameter int BUF_W  = 64,
  parameter int PUSH_W = 32,
  parameter int POP_W  = 8,
  parameter int LVL_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [PUSH_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [POP_W-1:0]  slice_o,
  output logic [LVL_W-1:0]  level_o
);

  logic [BUF_W-1:0] data_q, data_d, push_ext;
  logic [LVL_W-1:0] level_q, level_d;
  buf_op_e          op;

  assign push_ext = BUF_W'(push_data_i);
  assign op       = buf_op_e'({push_i, pop_i});

  // Bits above level stay zero, so a new word can simply be OR-ed in place.
  always_comb begin
    data_d  = data_q;
    level_d = level_q;
    if (clr_i) begin
      data_d  = '0;
      level_d = '0;
    end else begin
      case (op)
        BUF_POP: begin
          data_d  = data_q >> POP_W;
          level_d = level_q - LVL_W'(POP_W);
        end
        BUF_PUSH: begin
          data_d  = data_q | (push_ext << level_q);
          level_d = level_q + LVL_W'(PUSH_W);
        end
        BUF_BOTH: begin
          data_d  = (data_q >> POP_W) | (push_ext << (level_q - LVL_W'(POP_W)));
          level_d = level_q + LVL_W'(PUSH_W) - LVL_W'(POP_W);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      level_q <= '0;
    end else begin
      data_q  <= data_d;
      level_q <= level_d;
    end
  end

  assign slice_o = data_q[POP_W-1:0];
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/hpc3_rnd_dispatch.sv
`default_nettype none
// ============================================================================
// hpc3_rnd_dispatch : PRNG-to-HPC3 randomness dispatcher, each bit used once
// Rev 1.0
// ============================================================================
module hpc3_rnd_dispatch
  import hpc3_rnd_dispatch_pkg::*;
#(
  parameter  int D        = 2,
  parameter  int NGADGETS = 4,
  parameter  int PRNG_W   = 32,
  parameter  int BUF_W    = 64,
  localparam int HPC3RND  = hpc3_rnd_bits(D),
  localparam int OUT_W    = NGADGETS * HPC3RND,
  localparam int LVL_W    = clog2_fn(BUF_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PRNG_W-1:0] prng_data,
  input  logic              prng_valid,
  output logic              prng_ready,
  input  logic              flush,
  input  logic              rnd_ready,
  output logic              rnd_valid,
  output logic [OUT_W-1:0]  rnd,
  output logic [LVL_W-1:0]  level
);

  if (BUF_W < PRNG_W + OUT_W - 1) begin : g_bad_buf_w
    $error("hpc3_rnd_dispatch: BUF_W must be >= PRNG_W+OUT_W-1");
  end

  logic push, consume;

  // Both flags depend on level alone, keeping rnd_ready off the PRNG path.
  assign prng_ready = (level <= LVL_W'(BUF_W - PRNG_W));
  assign rnd_valid  = (level >= LVL_W'(OUT_W));

  // A flushing cycle accepts the PRNG word but drops it.
  assign push    = prng_valid & prng_ready & ~flush;
  assign consume = rnd_valid & rnd_ready & ~flush;

  hpc3_rnd_dispatch_rnd_bitbuf #(
    .BUF_W  (BUF_W),
    .PUSH_W (PRNG_W),
    .POP_W  (OUT_W),
    .LVL_W  (LVL_W)
  ) u_bitbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (flush),
    .push_i      (push),
    .push_data_i (prng_data),
    .pop_i       (consume),
    .slice_o     (rnd),
    .level_o     (level)
  );

endmodule
`default_nettype wire

// File: doc/hpc3_rnd_dispatch.md
Name: hpc3_rnd_dispatch

Overview:
- Randomness dispatch stage directly upstream of the masked HPC3 AND gadget bank. Feeds the `rnd` inputs of the plain, cross-domain and swapped cross-domain gadget variants.
- Accepts fixed-width words from the PRNG over a valid/ready handshake and buffers them as a bit stream.
- Each consumed cycle, delivers one fresh, never-reused slice of `NGADGETS*HPC3RND` bits to the gadget bank.
- Guarantees that every random bit reaches a gadget exactly once, or is discarded.

Parameters:
- d, 2, number of shares per sharing.
- NGADGETS, 4, number of HPC3 gadgets fed in parallel each cycle.
- PRNG_W, 32, width of one PRNG word.
- BUF_W, 64, bit capacity of the internal buffer; must be >= PRNG_W+OUT_W-1 (elaboration-time check).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- prng_data  in  PRNG_W  fresh random word.
- prng_valid  in  1  prng_data is valid.
- prng_ready  out  1  buffer can accept a word this cycle.
- flush  in  1  discard all buffered bits (reseed / key change).
- rnd_ready  in  1  gadget bank consumes the current slice this cycle.
- rnd_valid  out  1  rnd holds OUT_W unused bits.
- rnd  out  OUT_W  randomness slice to the gadgets, OUT_W=NGADGETS*HPC3RND; gadget g takes rnd[g*HPC3RND +: HPC3RND].
- level  out  clog2(BUF_W+1)  number of valid buffered bits.

Behaviour:
- Reset: rst_n low asynchronously clears buffer and count. All outputs go immediately to reset values: level=0, rnd_valid=0, rnd=0, prng_ready=1. Reset mid-operation drops all buffered bits, with no partial output.
- Storage: buf register of BUF_W bits; valid bits occupy buf[level-1:0]; all bits above level are held at 0.
- rnd = buf[OUT_W-1:0] combinationally from the register. rnd_valid = (level >= OUT_W). Gadgets use rnd only when a consume handshake fires.
- prng_ready = (level <= BUF_W-PRNG_W). It is a function of level only, with no combinational path from rnd_ready.
- push = prng_valid & prng_ready. consume = rnd_valid & rnd_ready.
- Next state, with L = level:
  - consume only: buf >>= OUT_W (zeros shift in); L -= OUT_W.
  - push only: buf[L +: PRNG_W] = prng_data; L += PRNG_W.
  - both: buf = (buf >> OUT_W) with prng_data written at L-OUT_W; L += PRNG_W-OUT_W.
  - neither: hold.
- Bit order is FIFO, LSB first: the oldest bit goes to rnd[0].
- flush (synchronous, highest priority): L=0 and buf=0 on the next edge; push and consume in the same cycle are ignored. prng_ready stays asserted, but the word is not stored; the PRNG must treat it as consumed and discarded.
- Full boundary: at L > BUF_W-PRNG_W, prng_ready=0 and prng_data is ignored.
- Empty boundary: at L < OUT_W, rnd_valid=0 and rnd_ready is ignored; no partial slice is ever issued.
- Freshness invariant: no bit index of the PRNG stream appears on rnd in two consume cycles.
- Latency: a word pushed at edge N is visible on rnd after edge N, if it lands in the low OUT_W bits.

Decomposition:
- Shared package/header: HPC3RND (random bits per HPC3 gadget, derived from d), OUT_W computation, clog2 helper.
- The buffer plus level counter is one natural sub-module, rnd_bitbuf, with push/pop of fixed widths. The dispatch top adds the handshake, flush and slice mapping.

Test Plan (d=2, NGADGETS=4, HPC3RND=2, OUT_W=8, PRNG_W=32, BUF_W=64):
- Release rst_n, no stimulus -> level=0, rnd_valid=0, rnd=0x00, prng_ready=1.
- Push 0xA5C30F12, then hold rnd_ready=1 -> rnd sequence 0x12, 0x0F, 0xC3, 0xA5 on four consume cycles; then rnd_valid=0, level=0.
- Push 0x11111111 and 0x22222222 with rnd_ready=0 -> level=64, prng_ready=0. A third push of 0x33333333 is ignored; next four slices are 0x11.
- level=8 (rnd=0x12), push 0xDEADBEEF with consume in the same cycle -> level=32, rnd=0xEF, 0xBE, 0xAD, 0xDE.
- level=40, flush=1 with prng_valid=1 and rnd_ready=1 -> next cycle level=0, rnd_valid=0; the pushed word is absent from all later rnd.
- level=40, rst_n pulsed low between edges -> rnd_valid=0 and level=0 immediately, before the next clk edge.
